// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared FSM encodings, port indices and timeout default for the data memory arbiter
package data_mem_arbiter_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    localparam int TIMEOUT_CYCLES_DEFAULT = 16;
endpackage

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter between two requesters sharing one data memory port
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req/we/addr/wdata/mask{0,1}      level requests and command fields per port
//   done0/done1, rdata, err          one-cycle completion pulse, read data, timeout flag
//   mem_read/mem_write               one-cycle command strobes
//   mem_addr/mem_wdata/mem_sign_mask command fields, held from ISSUE through RESP
//   mem_busy/mem_rdata               memory stall flag and read data
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [3:0]  mask0,
    input  logic [3:0]  mask1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sign_mask,
    input  logic        mem_busy,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          seen_busy, last_grant, cur, cmd_we, err_q;
    logic [31:0]   cmd_addr, cmd_wdata, rdata_q;
    logic [3:0]    cmd_mask;
    logic          grant, any_req, mem_done, tmo;
    assign any_req  = req0 || req1;
    // on contention the port that was not served last wins
    assign grant    = (req0 && req1) ? ~last_grant : req1;
    // completion is the first non-busy cycle after busy has been observed
    assign mem_done = seen_busy && !mem_busy;
    // this WAIT cycle is the TIMEOUT_CYCLES-th one
    assign tmo      = cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  state_nx = any_req ? S_ISSUE : S_IDLE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  state_nx = (mem_done || tmo) ? S_RESP : S_WAIT;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            seen_busy  <= 1'b0;
            last_grant <= PORT1;
            cur        <= PORT0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_mask   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state == S_IDLE && any_req) begin
                cur       <= grant;
                cmd_we    <= grant ? we1 : we0;
                cmd_addr  <= grant ? addr1 : addr0;
                cmd_wdata <= grant ? wdata1 : wdata0;
                cmd_mask  <= grant ? mask1 : mask0;
            end
            if (state == S_ISSUE) begin
                cnt       <= '0;
                seen_busy <= 1'b0;
            end
            if (state == S_WAIT) begin
                cnt <= cnt + CW'(1);
                if (mem_busy) seen_busy <= 1'b1;
                if (mem_done) begin
                    rdata_q <= cmd_we ? 32'h0 : mem_rdata;
                    err_q   <= 1'b0;
                end else if (tmo) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end
            end
            if (state == S_RESP) last_grant <= cur;
        end
    end
    always_comb begin
        mem_read  = state == S_ISSUE && !cmd_we;
        mem_write = state == S_ISSUE && cmd_we;
        done0     = state == S_RESP && cur == PORT0;
        done1     = state == S_RESP && cur == PORT1;
        rdata     = state == S_RESP ? rdata_q : 32'h0;
        err       = state == S_RESP && err_q;
    end
    assign mem_addr      = cmd_addr;
    assign mem_wdata     = cmd_wdata;
    assign mem_sign_mask = cmd_mask;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed, table-driven self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic [3:0]  mask0 = 0, mask1 = 0;
    logic        done0, done1, err, mem_read, mem_write, mem_busy;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_sign_mask;
    int          n_chk = 0, n_fail = 0;
    int          busy_len = 1, bcnt, rdp, wrp, lat;
    logic [31:0] mem_rd_val = 0;

    data_mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .mask0(mask0), .mask1(mask1),
        .done0(done0), .done1(done1), .rdata(rdata), .err(err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sign_mask(mem_sign_mask),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // memory model: busy for busy_len cycles starting the cycle after a command
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcnt <= 0;
        else if (mem_read || mem_write) bcnt <= busy_len;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign mem_busy  = bcnt != 0;
    assign mem_rdata = mem_rd_val;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          busy;
        logic [31:0] mrd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // counts negedges until a done pulse, with a bounded wait
    task automatic wait_done(output int n);
        n = 0; rdp = 0; wrp = 0;
        do begin
            @(negedge clk);
            n++;
            rdp += int'(mem_read);
            wrp += int'(mem_write);
        end while (!(done0 || done1) && n < 60);
        chk("done_seen", 32'(done0 || done1), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_done"}, {30'd0, done1, done0}, 32'd0);
        chk({tag, "_strobe"}, {30'd0, mem_write, mem_read}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rdata_err"}, rdata | 32'(err) | 32'(mem_sign_mask), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h4010, 32'h0,        4'h3, 2,    32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 5};
        vecs[1] = '{1'b1, 1'b0, 32'h8000, 32'h0,        4'h1, 1,    32'h12345678, 32'h12345678, 1'b0, 4};
        vecs[2] = '{1'b0, 1'b1, 32'h0100, 32'h0000AA55, 4'hF, 3,    32'hFFFFFFFF, 32'h0,        1'b0, 6};
        vecs[3] = '{1'b0, 1'b0, 32'h2000, 32'h0,        4'h5, 1000, 32'h77777777, 32'h0,        1'b1, 18};
        vecs[4] = '{1'b1, 1'b0, 32'h2004, 32'h0,        4'h2, 15,   32'h0BADF00D, 32'h0BADF00D, 1'b0, 18};
        vecs[5] = '{1'b1, 1'b0, 32'h2008, 32'h0,        4'h8, 16,   32'h0BADF00D, 32'h0,        1'b1, 18};

        #1 check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // simultaneous writes after reset: port 0 first, port 1 right after
        busy_len = 1;
        we0 = 1; addr0 = 32'h200; wdata0 = 32'h11111111; req0 = 1;
        we1 = 1; addr1 = 32'h300; wdata1 = 32'h22222222; req1 = 1;
        wait_done(lat);
        chk("first_port0", {30'd0, done1, done0}, 32'd1);
        chk("first_wdata", mem_wdata, 32'h11111111);
        chk("first_lat", lat, 4);
        chk("first_write_strobes", {wrp[15:0], rdp[15:0]}, {16'd1, 16'd0});
        req0 = 0;
        wait_done(lat);
        chk("second_port1", {30'd0, done1, done0}, 32'd2);
        chk("second_wdata", mem_wdata, 32'h22222222);
        chk("second_addr", mem_addr, 32'h300);
        chk("second_lat", lat, 5);
        req1 = 0;
        @(negedge clk);

        // continuous contention alternates grants starting with port 0
        we0 = 0; we1 = 0; req0 = 1; req1 = 1;
        for (int i = 0; i < 6; i++) begin
            wait_done(lat);
            chk("rr_port", 32'(done1), 32'(i % 2));
            chk("rr_exclusive", 32'(done0 && done1), 32'd0);
        end
        req0 = 0; req1 = 0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            busy_len = vecs[i].busy;
            mem_rd_val = vecs[i].mrd;
            if (vecs[i].port) begin
                we1 = vecs[i].we; addr1 = vecs[i].addr; wdata1 = vecs[i].wdata; mask1 = vecs[i].mask; req1 = 1;
            end else begin
                we0 = vecs[i].we; addr0 = vecs[i].addr; wdata0 = vecs[i].wdata; mask0 = vecs[i].mask; req0 = 1;
            end
            wait_done(lat);
            chk($sformatf("v%0d_done_port", i), {30'd0, done1, done0}, vecs[i].port ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_strobes", i), {wrp[15:0], rdp[15:0]}, vecs[i].we ? {16'd1, 16'd0} : {16'd0, 16'd1});
            chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("v%0d_mask", i), 32'(mem_sign_mask), 32'(vecs[i].mask));
            req0 = 0; req1 = 0;
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", i), {29'd0, err, done1, done0}, 32'd0);
        end

        // address change on port 1 during WAIT does not reach memory
        busy_len = 3; mem_rd_val = 32'h13579BDF;
        we1 = 0; addr1 = 32'h4000; req1 = 1;
        repeat (2) @(negedge clk);
        addr1 = 32'h4100;
        wait_done(lat);
        chk("hold_done1", 32'(done1), 32'd1);
        chk("hold_addr", mem_addr, 32'h4000);
        chk("hold_rdata", rdata, 32'h13579BDF);
        req1 = 0;
        @(negedge clk);

        // reset while in WAIT abandons the transaction
        busy_len = 1000;
        we1 = 0; addr1 = 32'h5000; req1 = 1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        req1 = 0;
        lat = 0;
        repeat (3) begin
            @(negedge clk);
            lat += int'(done0 || done1);
        end
        chk("midreset_no_done", lat, 0);
        rst_n = 1'b1;
        @(negedge clk);
        busy_len = 1; mem_rd_val = 32'hCAFEF00D;
        addr1 = 32'h6000; req1 = 1;
        wait_done(lat);
        chk("after_reset_done1", {30'd0, done1, done0}, 32'd2);
        chk("after_reset_rdata", rdata, 32'hCAFEF00D);
        chk("after_reset_lat", lat, 4);
        req1 = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
